sample_uart_tx: RTL
===================

Name: sample_uart_tx

Overview:
- Consumer end of the filtered-sample stream in the glove datapath.
- Periodically captures the signed 15-bit output of the moving-average filter and ships it off-chip as a 4-byte UART frame: sync, MSB, LSB, checksum.
- Format is 8N1, LSB first.
- Sits between the filter output and the board TX pin.

Parameters:
- CLKS_PER_BIT, 434, clock_in cycles per UART bit (50 MHz / 115200); must be ≥ 2.
- SAMPLE_DIV, 50000, clock_in cycles between capture attempts; must be ≥ 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clock_in  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- enable  input  1  high = capture timer runs; low = timer held at 0.
- sample_in  input  15  signed filtered sample, sampled only on capture cycles.
- overrun_clr  input  1  synchronous clear of overrun.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is being shifted.
- overrun  output  1  sticky: a capture tick occurred while busy.
- frame_count  output  8  frames started, wraps 255→0.

Behaviour:
- Reset (asynchronous, reset=0):
  - tx=1, busy=0, overrun=0, frame_count=0.
  - Timers 0, FSM=IDLE, holding regs 0.
  - Applies immediately, including mid-frame; the line returns high with no stop bit.
- Capture timer:
  - While enable=1, counts 0..SAMPLE_DIV-1 and wraps. While enable=0, held at 0.
  - The tick is the cycle where the count equals SAMPLE_DIV-1 and enable=1.
- On tick with FSM=IDLE:
  - Latch sample_in sign-extended to 16 bits (S).
  - Load bytes: B0=SYNC_BYTE, B1=S[15:8], B2=S[7:0], B3=B1^B2.
  - Byte index = 0, FSM→START, frame_count+1.
- On tick with FSM≠IDLE: sample dropped, overrun←1, and the frame in progress is unaffected.
- overrun clears on overrun_clr=1 unless a drop occurs the same cycle; set wins.
- FSM states:
  - IDLE: tx=1, busy=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then →DATA with bit index 0.
  - DATA: tx=current byte[bit index] for CLKS_PER_BIT cycles per bit, bits 0..7. After bit 7 →STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte index<3, increment it and →START; else →IDLE.
- busy=1 in START/DATA/STOP; it is registered and asserts the cycle after the tick.
- tx is registered. The first start-bit low appears the cycle after the tick.
- Frame duration is exactly 40·CLKS_PER_BIT cycles. After STOP of B3, busy falls and the next tick may capture.
- Bytes are back-to-back: no idle gap between the STOP of one byte and the START of the next.
- Bit timer counts 0..CLKS_PER_BIT-1 and resets on every bit transition.
- enable falling mid-frame: the current frame completes unchanged; only the timer stops.
- sample_in changing mid-frame has no effect; the frame is captured atomically.
- Sign extension: sample_in[14] replicated into S[15].

Test Plan:
- Setup: CLKS_PER_BIT=4, SAMPLE_DIV=200.
- Basic frame: reset low 3 cycles, release, enable=1, sample_in=15'h1234.
  - First tick is 199 cycles after release, with tx low the following cycle.
  - Decoded bytes A5 12 34 26.
  - busy high exactly 160 cycles; frame_count=1.
- Sign extension: sample_in=-1 → bytes A5 FF FF 00. sample_in=15'h4000 (−16384) → A5 C0 00 C0.
- Periodicity: hold enable for 1000 cycles.
  - Frames start every 200 cycles; frame_count=5; overrun stays 0.
  - tx high in each 40-cycle gap.
- Overrun: rebuild with SAMPLE_DIV=100.
  - overrun sets at the second tick (frame 1 still busy).
  - Frames only start on ticks seen while idle.
  - Pulse overrun_clr → overrun=0 next cycle. Pulse it again coincident with a drop → stays 1.
- Enable/reset mid-frame:
  - Drop enable at cycle 50 of a frame → the frame completes, no further frames start.
  - Assert reset at cycle 80 of a frame → tx=1, busy=0, frame_count=0 within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/sample_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : sample_uart_tx
// Purpose  : Periodically captures a signed 15-bit filtered sample and sends it
//            as a 4-byte 8N1 UART frame: sync, MSB, LSB, checksum (MSB ^ LSB).
// Revision : 1.0
// ============================================================================
module sample_uart_tx #(
    parameter int           CLKS_PER_BIT = 434,
    parameter int           SAMPLE_DIV   = 50000,
    parameter logic [7:0]   SYNC_BYTE    = 8'hA5
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        enable,
    input  logic [14:0] sample_in,
    input  logic        overrun_clr,
    output logic        tx,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  frame_count
);

    localparam int DIV_W = (SAMPLE_DIV   > 1) ? $clog2(SAMPLE_DIV)   : 1;
    localparam int BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] c_div_max = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0] c_bit_max = BIT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [DIV_W-1:0]      r_div;
    logic [BIT_W-1:0]      r_bit_tmr;
    logic [2:0]            r_bit_idx;
    logic [1:0]            r_byte_idx;
    logic [3:0][7:0]       r_bytes;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_overrun;
    logic [7:0]            r_frame_cnt;

    logic                  w_tick;
    logic                  w_bit_done;
    logic [15:0]           w_sample_ext;
    logic [7:0]            w_cur_byte;
    logic [2:0]            w_next_bit_idx;

    assign w_tick         = enable && (r_div == c_div_max);
    assign w_bit_done     = (r_bit_tmr == c_bit_max);
    assign w_sample_ext   = {sample_in[14], sample_in};
    assign w_cur_byte     = r_bytes[r_byte_idx];
    assign w_next_bit_idx = r_bit_idx + 3'd1;

    assign tx          = r_tx;
    assign busy        = r_busy;
    assign overrun     = r_overrun;
    assign frame_count = r_frame_cnt;

    // Capture timer: free-runs only while enabled, otherwise parked at zero
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (!enable || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // A tick that arrives while a frame is in flight is dropped; set beats clear
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (w_tick && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_bit_tmr   <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_bytes     <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_tick) begin
                        r_bytes[0]  <= SYNC_BYTE;
                        r_bytes[1]  <= w_sample_ext[15:8];
                        r_bytes[2]  <= w_sample_ext[7:0];
                        r_bytes[3]  <= w_sample_ext[15:8] ^ w_sample_ext[7:0];
                        r_byte_idx  <= '0;
                        r_bit_tmr   <= '0;
                        r_state     <= S_START;
                        r_tx        <= 1'b0;
                        r_busy      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_bit_tmr <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= w_cur_byte[0];
                    end else begin
                        r_bit_tmr <= r_bit_tmr + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_bit_tmr <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= w_next_bit_idx;
                            r_tx      <= w_cur_byte[w_next_bit_idx];
                        end
                    end else begin
                        r_bit_tmr <= r_bit_tmr + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_bit_tmr <= '0;
                        // Next byte's start bit follows the stop bit with no idle gap
                        if (r_byte_idx != 2'd3) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= S_START;
                            r_tx       <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_bit_tmr <= r_bit_tmr + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
